// File: rtl/sap_control_seq.sv
// sap_control_seq: ring-counter control sequencer for the SAP-class CPU.
// Drives the 12-bit control word from a one-hot T-state ring and the IR
// opcode, with flag-conditional jumps, early return to T1, halt and
// single-step gating. State advances on the falling clock edge so the
// combinational control word is settled for the datapath's rising edges.
module sap_control_seq #(
  parameter int unsigned RING_LEN  = 6,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned SKIP_IDLE = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic                zero_flag,
  input  logic                neg_flag,
  input  logic                step_mode,
  input  logic                step,
  output logic [11:0]         CON,
  output logic                pc_load,
  output logic                halted,
  output logic [RING_LEN-1:0] t_state
);

  localparam logic [RING_LEN-1:0] T1 = RING_LEN'(1);

  // Control words {Cp,Ep,Lm',CE',Li',Ei',La',Ea,Su,Eu,Lb',Lo'}
  localparam logic [11:0] CON_IDLE  = 12'h3E3;
  localparam logic [11:0] CON_T1    = 12'h5E3;
  localparam logic [11:0] CON_T2    = 12'hBE3;
  localparam logic [11:0] CON_T3    = 12'h263;
  localparam logic [11:0] CON_IR_MA = 12'h1A3;
  localparam logic [11:0] CON_LDA5  = 12'h2C3;
  localparam logic [11:0] CON_RD_B  = 12'h2E1;
  localparam logic [11:0] CON_ADD6  = 12'h3C7;
  localparam logic [11:0] CON_SUB6  = 12'h3CF;
  localparam logic [11:0] CON_JMP   = 12'h3A3;
  localparam logic [11:0] CON_OUT   = 12'h3F2;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_JN  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] OP_NOP = 4'h6;

  logic [RING_LEN-1:0] r_t_state;
  logic                r_halted;
  logic [RING_LEN-1:0] w_t_next;
  logic                w_halt_next;
  logic                w_adv;
  logic                w_onehot;
  logic [3:0]          w_op;
  logic [11:0]         w_word;
  logic                w_jump;
  logic                w_last;

  // Advance qualifier: halted freezes the ring; step mode gates each edge
  assign w_adv = !r_halted && (!step_mode || step);

  // Ring is legal only when exactly one bit is set
  assign w_onehot = (r_t_state != '0) && ((r_t_state & (r_t_state - T1)) == '0);

  // Opcodes with any upper bit set decode as NOP
  assign w_op = ((opcode >> 4) == '0) ? opcode[3:0] : OP_NOP;

  // Micro-op decode for the current T state: word, jump strobe, last-state flag
  always_comb begin
    w_word = CON_IDLE;
    w_jump = 1'b0;
    w_last = 1'b0;
    if (!w_onehot) begin
      w_word = CON_IDLE;
    end else if (r_t_state[0]) begin
      w_word = CON_T1;
    end else if (r_t_state[1]) begin
      w_word = CON_T2;
    end else if (r_t_state[2]) begin
      w_word = CON_T3;
    end else if (r_t_state[3]) begin
      case (w_op)
        OP_LDA, OP_ADD, OP_SUB: w_word = CON_IR_MA;
        OP_JMP: begin
          w_word = CON_JMP;
          w_jump = 1'b1;
          w_last = 1'b1;
        end
        OP_JZ: begin
          w_word = zero_flag ? CON_JMP : CON_IDLE;
          w_jump = zero_flag;
          w_last = 1'b1;
        end
        OP_JN: begin
          w_word = neg_flag ? CON_JMP : CON_IDLE;
          w_jump = neg_flag;
          w_last = 1'b1;
        end
        OP_OUT: begin
          w_word = CON_OUT;
          w_last = 1'b1;
        end
        default: w_last = 1'b1;
      endcase
    end else if (r_t_state[4]) begin
      case (w_op)
        OP_LDA: begin
          w_word = CON_LDA5;
          w_last = 1'b1;
        end
        OP_ADD, OP_SUB: w_word = CON_RD_B;
        default: w_word = CON_IDLE;
      endcase
    end else if (r_t_state[5]) begin
      case (w_op)
        OP_ADD: begin
          w_word = CON_ADD6;
          w_last = 1'b1;
        end
        OP_SUB: begin
          w_word = CON_SUB6;
          w_last = 1'b1;
        end
        default: w_word = CON_IDLE;
      endcase
    end
  end

  // A stalled or halted state drives the idle word so no load re-fires
  assign CON     = w_adv ? w_word : CON_IDLE;
  assign pc_load = w_adv && w_jump;

  // Next-state: recover, halt, early return to T1, or rotate the ring
  always_comb begin
    w_t_next    = r_t_state;
    w_halt_next = r_halted;
    if (w_adv) begin
      if (!w_onehot) begin
        w_t_next = T1;
      end else if (r_t_state[3] && (w_op == OP_HLT)) begin
        w_halt_next = 1'b1;
      end else if ((SKIP_IDLE != 0) && w_last) begin
        w_t_next = T1;
      end else begin
        w_t_next = {r_t_state[RING_LEN-2:0], r_t_state[RING_LEN-1]};
      end
    end
  end

  // State register on the falling edge with synchronous reset
  always_ff @(negedge clock) begin
    if (reset) begin
      r_t_state <= T1;
      r_halted  <= 1'b0;
    end else begin
      r_t_state <= w_t_next;
      r_halted  <= w_halt_next;
    end
  end

  assign t_state = r_t_state;
  assign halted  = r_halted;

endmodule
